// File: rtl/shift_pkg.sv
// Shared types for the shift pipeline: op codes and the S1 payload.
package shift_pkg;

   typedef enum logic [2:0] {
      OP_SLL = 3'd0,
      OP_SRL = 3'd1,
      OP_SRA = 3'd2,
      OP_ROL = 3'd3,
      OP_ROR = 3'd4
   } shift_op_e;

   localparam int MAX_W   = 64;
   localparam int MAX_TAG = 16;
   localparam int FUN_W   = 2 * (MAX_W + 2);

   // fun holds the coarse-shifted funnel, res the remaining 0..7 bits
   typedef struct packed {
      logic [FUN_W-1:0]   fun;
      logic [2:0]         res;
      shift_op_e          op;
      logic [MAX_TAG-1:0] tag;
      logic               err;
   } stage_t;

   function automatic logic is_left(shift_op_e op);
      return (op == OP_SLL) || (op == OP_ROL);
   endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Operand/result handshake bundle for shift_pipe.
interface shift_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   localparam int AW = $clog2(WIDTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [AW-1:0]    in_amt;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;

   modport master (
      output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_carry, out_tag, out_err
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_carry, out_tag, out_err
   );

endinterface

// File: rtl/funnel_stage.sv
// 2*W-to-W right funnel shift: low W bits of {hi,lo} >> amt.
module funnel_stage #(
   parameter int W  = 8,
   parameter int SW = $clog2(W) + 1
) (
   input  logic [W-1:0]  hi_i,
   input  logic [W-1:0]  lo_i,
   input  logic [SW-1:0] amt_i,
   output logic [W-1:0]  res_o
);

   logic [W-1:0] unused_hi;

   assign {unused_hi, res_o} = {hi_i, lo_i} >> amt_i;

endmodule

// File: rtl/shift_pipe.sv
// Two-stage shifter: S1 decodes and shifts by multiples of 8,
// S2 finishes the shift, picks the carry and drives the outputs.
module shift_pipe
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   shift_pipe_if.slave bus
);

   localparam int AW  = $clog2(WIDTH) + 1;
   localparam int FW  = WIDTH + 2;
   localparam int PW  = 2 * FW;
   localparam int SW1 = $clog2(PW) + 1;
   localparam int SW2 = $clog2(FW) + 1;

   logic [WIDTH-1:0] d, hi, lo;
   logic [AW-1:0]    a, k, s, sp, wa;
   logic             over, ill;
   shift_op_e        op_d;
   logic [PW-1:0]    g, p1;
   stage_t           s1_d, s1_q;
   logic             v1_q, v2_q, s1_adv, s2_adv;
   logic [FW-1:0]    r2;
   logic             carry_d;
   logic [WIDTH-1:0] data_q;
   logic             carry_q, err_q;
   logic [TAG_W-1:0] tag_q;
   logic             s1_unused;

   assign d    = bus.in_data;
   assign a    = bus.in_amt;
   assign wa   = AW'(WIDTH);
   assign over = a > wa;
   assign k    = a & (wa - AW'(1));

   always_comb begin
      hi   = '0;
      lo   = '0;
      s    = '0;
      ill  = 1'b0;
      op_d = OP_SRL;
      unique case (1'b1)
         bus.in_op == 3'(OP_SLL): begin
            op_d = OP_SLL;
            hi   = over ? '0 : d;
            s    = over ? wa : wa - a;
         end
         bus.in_op == 3'(OP_SRL): begin
            lo = over ? '0 : d;
            s  = over ? '0 : a;
         end
         bus.in_op == 3'(OP_SRA): begin
            op_d = OP_SRA;
            hi   = {WIDTH{d[WIDTH-1]}};
            lo   = d;
            s    = over ? wa : a;
         end
         bus.in_op == 3'(OP_ROL): begin
            op_d = OP_ROL;
            hi   = d;
            lo   = d;
            s    = wa - k;
         end
         bus.in_op == 3'(OP_ROR): begin
            op_d = OP_ROR;
            hi   = d;
            lo   = d;
            s    = k;
         end
         default: ill = 1'b1;
      endcase
   end

   // Guard bits either side: after >> (s+1), bit 0 is the last bit
   // shifted out low and bit WIDTH+1 the first bit beyond the top.
   assign sp = s + AW'(1);
   assign g  = {2'b00, hi, lo, 2'b00};

   funnel_stage #(.W(PW), .SW(SW1)) u_s1 (
      .hi_i  ('0),
      .lo_i  (g),
      .amt_i (SW1'({sp[AW-1:3], 3'b000})),
      .res_o (p1)
   );

   assign s1_d = '{
      fun: FUN_W'(p1),
      res: sp[2:0],
      op:  op_d,
      tag: MAX_TAG'(bus.in_tag),
      err: ill
   };

   funnel_stage #(.W(FW), .SW(SW2)) u_s2 (
      .hi_i  (s1_q.fun[PW-1:FW]),
      .lo_i  (s1_q.fun[FW-1:0]),
      .amt_i (SW2'(s1_q.res)),
      .res_o (r2)
   );

   assign carry_d   = is_left(s1_q.op) ? r2[WIDTH+1] : r2[0];
   assign s1_unused = ^s1_q;

   assign s2_adv       = !v2_q || bus.out_ready;
   assign s1_adv       = !v1_q || s2_adv;
   assign bus.in_ready = rst_n && s1_adv;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         s1_q    <= '0;
         data_q  <= '0;
         carry_q <= 1'b0;
         tag_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (s1_adv) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) s1_q <= s1_d;
         end
         if (s2_adv) begin
            v2_q <= v1_q;
            if (v1_q) begin
               data_q  <= r2[WIDTH:1];
               carry_q <= carry_d;
               tag_q   <= s1_q.tag[TAG_W-1:0];
               err_q   <= s1_q.err;
            end
         end
      end
   end

   assign bus.out_valid = v2_q;
   assign bus.out_data  = data_q;
   assign bus.out_carry = carry_q;
   assign bus.out_tag   = tag_q;
   assign bus.out_err   = err_q;

endmodule
